// File: rtl/bcd_serial_sub100.sv
// ---------------------------------------------------------------------------
// bcd_serial_sub100
//
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one BCD digit per
// clock, least significant digit first. A subtraction takes NDIG cycles in
// RUN, followed by a single DONE cycle that pulses done.
//
// Ports
//   clk    : single clock, all state changes on the rising edge
//   rst    : synchronous active-high reset (overrides start)
//   start  : begin a subtraction; only looked at while idle
//   a      : minuend, packed BCD, digit i at [4i+3:4i]
//   b      : subtrahend, same packing as a
//   bin    : borrow into digit 0
//   diff   : packed-BCD result (ten's complement when bout=1)
//   bout   : borrow out of the most significant digit
//   busy   : high while digits are being processed (RUN)
//   done   : one-cycle pulse; diff, bout and err are valid from here on
//   err    : sticky flag, some digit of a or b was not a valid BCD digit
// ---------------------------------------------------------------------------
module bcd_serial_sub100 #(
    parameter int NDIG = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              bin,
    output logic [4*NDIG-1:0] diff,
    output logic              bout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int W     = 4 * NDIG;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Operands are captured into shift registers so the active digit is
    // always in the low nibble; this avoids a wide NDIG:1 digit multiplexer.
    logic [W-1:0]     a_sh_reg;
    logic [W-1:0]     b_sh_reg;
    logic [W-1:0]     diff_reg;
    logic             borrow_reg;
    logic             bout_reg;
    logic             err_reg;
    logic [IDX_W-1:0] idx_reg;

    // ---------------------------------------------------------------------
    // Single-digit subtract stage
    // ---------------------------------------------------------------------
    logic [3:0] a_dig;
    logic [3:0] b_dig;
    logic [4:0] r;
    logic [3:0] dig_out;
    logic       dig_borrow;
    logic       dig_bad;
    logic [W-1:0] diff_shift;

    always_comb begin
        a_dig      = a_sh_reg[3:0];
        b_dig      = b_sh_reg[3:0];
        // 5-bit two's complement: bit 4 set means the digit went negative.
        r          = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, borrow_reg};
        dig_bad    = (a_dig > 4'd9) || (b_dig > 4'd9);
        dig_out    = r[3:0];
        dig_borrow = 1'b0;
        if (dig_bad) begin
            // Invalid input digit: emit 0 and restart the borrow chain.
            dig_out    = 4'd0;
            dig_borrow = 1'b0;
        end else if (r[4]) begin
            // r is in -10..-1; adding 10 modulo 16 yields the BCD digit.
            dig_out    = r[3:0] + 4'd10;
            dig_borrow = 1'b1;
        end
    end

    // Result digits enter at the top and move down, so after NDIG shifts
    // digit i sits at [4i+3:4i].
    generate
        if (NDIG > 1) begin : g_shift_wide
            assign diff_shift = {dig_out, diff_reg[W-1:4]};
        end else begin : g_shift_single
            assign diff_shift = dig_out;
        end
    endgenerate

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (idx_reg == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
            err_reg    <= 1'b0;
            idx_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg   <= a;
                        b_sh_reg   <= b;
                        borrow_reg <= bin;
                        diff_reg   <= '0;
                        bout_reg   <= 1'b0;
                        err_reg    <= 1'b0;
                        idx_reg    <= '0;
                    end
                end
                RUN: begin
                    a_sh_reg   <= a_sh_reg >> 4;
                    b_sh_reg   <= b_sh_reg >> 4;
                    diff_reg   <= diff_shift;
                    borrow_reg <= dig_borrow;
                    if (dig_bad) begin
                        err_reg <= 1'b1;
                    end
                    if (idx_reg == LAST_IDX) begin
                        bout_reg <= dig_borrow;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;
    assign err  = err_reg;
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_bcd_serial_sub100.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_sub100
//
// Directed testbench for bcd_serial_sub100 (NDIG=100). The stimulus process
// pushes the hand-computed result and the expected done cycle into a
// scoreboard queue when it issues start; an independent monitor pops and
// compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_bcd_serial_sub100;

    localparam int NDIG = 100;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;
    logic         err;

    bcd_serial_sub100 #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         err;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            chk("done_busy_overlap", W'(busy), W'(0));
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, ".diff"}, diff, e.diff);
                chk({e.name, ".bout"}, W'(bout), W'(e.bout));
                chk({e.name, ".err"},  W'(err),  W'(e.err));
                chk({e.name, ".done_cycle"}, W'(cyc), W'(e.cyc));
                $display("txn %s: cycle=%0d bout=%0b err=%0b diff=%h", e.name, cyc, bout, err, diff);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout: got busy=%0b done=%0b expected idle", busy, done);
        end
    endtask

    task automatic wait_busy();
        int n = 0;
        @(negedge clk);
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!busy) begin
            checks++;
            failures++;
            $display("FAIL wait_busy_timeout: got busy=0 expected 1");
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic er,
                                input string name);
        exp_t e;
        e.diff = d;
        e.bout = bo;
        e.err  = er;
        e.cyc  = cyc + NDIG + 1;   // sampled at the negedge before the accepting edge
        e.name = name;
        return e;
    endfunction

    // Issue one subtraction from IDLE, then scramble the inputs mid-run.
    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic binv, input logic [W-1:0] ed, input logic eb,
                          input logic ee);
        wait_idle();
        a     = av;
        b     = bv;
        bin   = binv;
        start = 1'b1;
        sb_q.push_back(mk(ed, eb, ee, name));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~av;
        b     = {NDIG{4'h3}};
        bin   = ~binv;
    endtask

    // ---------------- main stimulus ----------------
    logic [W-1:0] all9;
    logic [W-1:0] v57;
    logic [W-1:0] m3;
    int           n_done_before;

    initial begin
        all9 = {NDIG{4'h9}};
        v57  = '0;
        v57[57*4 +: 4] = 4'hC;
        m3   = all9;
        m3[3:0] = 4'h7;            // 5 - 7 - 1 = -3 -> 10^100 - 3

        rst   = 1'b1;
        start = 1'b1;              // reset must win over start
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("reset.diff", diff, '0);
        chk("reset.bout", W'(bout), W'(0));
        chk("reset.err",  W'(err),  W'(0));
        chk("reset.busy", W'(busy), W'(0));
        chk("reset.done", W'(done), W'(0));
        rst = 1'b0;

        run_op("sub_523_178", W'(12'h523), W'(12'h178), 1'b0, W'(12'h345), 1'b0, 1'b0);
        run_op("zero_minus_one", '0, W'(1), 1'b0, all9, 1'b1, 1'b0);
        run_op("nines_bin1", all9, all9, 1'b1, all9, 1'b1, 1'b0);
        run_op("nines_bin0", all9, all9, 1'b0, '0, 1'b0, 1'b0);
        run_op("bad_digit57", v57, '0, 1'b0, '0, 1'b0, 1'b1);
        run_op("bad_b_digit0", W'(8'h10), W'(8'h0F), 1'b0, W'(8'h10), 1'b0, 1'b1);
        run_op("sub_1000_1", W'(16'h1000), W'(1), 1'b0, W'(12'h999), 1'b0, 1'b0);
        run_op("sub_5_7_bin1", W'(4'h5), W'(4'h7), 1'b1, m3, 1'b1, 1'b0);

        // Outputs hold while idle with start low.
        wait_idle();
        repeat (5) @(negedge clk);
        chk("hold.diff", diff, m3);
        chk("hold.bout", W'(bout), W'(1));
        chk("hold.err",  W'(err),  W'(0));

        // Reset in the middle of RUN (digit 40 active).
        wait_idle();
        a     = all9;
        b     = W'(1);
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.diff", diff, '0);
        chk("midrst.bout", W'(bout), W'(0));
        chk("midrst.err",  W'(err),  W'(0));
        chk("midrst.busy", W'(busy), W'(0));
        chk("midrst.done", W'(done), W'(0));
        n_done_before = done_cnt;
        repeat (NDIG + 10) @(negedge clk);
        chk("midrst.no_done", W'(done_cnt - n_done_before), W'(0));

        run_op("after_reset", W'(12'h523), W'(12'h178), 1'b0, W'(12'h345), 1'b0, 1'b0);

        // start held high: back-to-back runs every NDIG+2 cycles, inputs
        // scrambled mid-run.
        wait_idle();
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_idle();
            case (k)
                0: begin a = W'(12'h523); b = W'(12'h178); bin = 1'b0;
                         sb_q.push_back(mk(W'(12'h345), 1'b0, 1'b0, "cont0")); end
                1: begin a = W'(16'h1000); b = W'(1); bin = 1'b0;
                         sb_q.push_back(mk(W'(12'h999), 1'b0, 1'b0, "cont1")); end
                default: begin a = W'(4'h5); b = W'(4'h7); bin = 1'b1;
                         sb_q.push_back(mk(m3, 1'b1, 1'b0, "cont2")); end
            endcase
            wait_busy();
            if (k == 2) start = 1'b0;
            repeat (20) @(negedge clk);
            a   = {NDIG{4'h8}};
            b   = {NDIG{4'h1}};
            bin = ~bin;
        end

        // Drain the scoreboard.
        begin
            int n = 0;
            while (sb_q.size() != 0 && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (sb_q.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            end
        end
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
